tff_bank_arbiter: RTL and testbench
===================================

// Module: tff_bank_arbiter
// PURPOSE
//   Round-robin arbiter and sequencer for one shared bank of WIDTH T flip-flops.
//   Each bank bit is a D flop fed with D = T ^ Q.
//   NREQ requesters each present a toggle mask. The block grants one requester at a time,
//   applies its mask as the T inputs for exactly one clock, then returns the updated bank value with an ack.
//   It sits between the control clients and the toggle-register bank; nothing else drives the bank's T inputs.
// PARAMETERS
//   NREQ   4   number of requesters (2..16)
//   WIDTH  8   number of T flip-flops in the shared bank
// PORTS
//   clk      in   1           rising-edge clock; the only clock
//   rst      in   1           asynchronous, active-low reset
//   req      in   NREQ        per-requester request; hold high until ack while own gnt bit is set
//   mask     in   NREQ*WIDTH  per-requester toggle mask; requester i uses bits [i*WIDTH +: WIDTH]
//   clr      in   1           synchronous clear of the bank to 0
//   gnt      out  NREQ        one-hot grant, registered
//   ack      out  1           one-cycle pulse: transaction of the granted requester complete
//   rdata    out  WIDTH       bank value after the toggle; valid while ack=1
//   bank_q   out  WIDTH       live bank state (the T-FF Q outputs)
//   busy     out  1           high in any state other than IDLE
// BEHAVIOUR
//   Reset (rst=0, async): FSM=IDLE, gnt=0, ack=0, rdata=0, bank_q=0, busy=0, rr pointer=0.
//   FSM states:
//   - IDLE: if req!=0, pick the first set req bit scanning ptr, ptr+1, ..., wrapping mod NREQ.
//     Latch that requester's mask, set gnt one-hot, go to APPLY. If req==0, stay in IDLE.
//   - APPLY: bank_q <= bank_q ^ mask_latched (T=mask for one edge).
//     Then rdata <= the new value, ack <= 1, go to ACK.
//   - ACK: ack high for this single cycle; gnt held.
//     At the next edge: gnt=0, ack=0, ptr <= (winner+1) mod NREQ, go to IDLE.
//   Latency: req high before edge E0 in IDLE gives gnt after E0, bank update and ack after E1,
//     and gnt/ack low after E2.
//   Throughput: one grant per 3 cycles. The next arbitration happens at the first IDLE edge after ACK.
//   mask is sampled only at the grant edge. Later changes, or req dropping early, do not affect the transaction.
//   A transaction is never aborted except by rst.
//   Zero mask: the bank is unchanged, but the full IDLE->APPLY->ACK sequence and ack still occur.
//   clr=1 at an edge forces bank_q=0 in any state and has priority over the APPLY toggle.
//   If clr coincides with APPLY, rdata=0, ack still pulses, and the FSM proceeds normally.
//   Fairness: a requester that just won has lowest priority in the next arbitration.
//     Any continuously requesting client is served within NREQ grants.
//   Pointer wrap: winner NREQ-1 sets ptr=0.
//   rst low mid-transaction: everything returns to reset values immediately.
//     The partial transaction is lost, with no ack.
//   gnt is always one-hot or zero. ack is never high in IDLE or APPLY.
// TESTING
//   1. Reset then idle: rst=0 then 1, req=0 for 10 cycles
//      -> gnt=0, ack=0, busy=0, bank_q=8'h00 throughout.
//   2. Single toggle: req=4'b0001, mask0=8'hA5
//      -> gnt=0001 after E0; bank_q=8'hA5, ack=1, rdata=8'hA5 after E1; gnt=0 after E2.
//      Repeat the same request -> bank_q=8'h00.
//   3. Round-robin: req=4'b1111 held, masks 01/02/04/08
//      -> grant order 0,1,2,3,0 (one per 3 cycles); bank_q after 4 acks = 8'h0F.
//   4. Pointer wrap and skip: after a grant to requester 3, req=4'b1010
//      -> next grant goes to requester 1, not 3.
//   5. clr vs APPLY: bank_q=8'hFF, grant with mask=8'h0F, clr=1 on the APPLY edge
//      -> bank_q=8'h00, rdata=8'h00, ack still pulses once.
//   6. Async reset mid-transaction: assert rst=0 during APPLY
//      -> gnt, ack, bank_q and busy go to 0 without waiting for clk; no ack is ever issued.
//      After release, req=4'b0001 is granted first (ptr=0).

Source files
------------

// File: rtl/tff_bank_arbiter_if.sv
// Client-side bundle for the shared T-flip-flop bank arbiter: requests/masks in,
// grant/ack/readback out.
interface tff_bank_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
);
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] mask;
    logic                  clr;
    logic [NREQ-1:0]       gnt;
    logic                  ack;
    logic [WIDTH-1:0]      rdata;
    logic [WIDTH-1:0]      bank_q;
    logic                  busy;

    modport master (output req, mask, clr, input gnt, ack, rdata, bank_q, busy);
    modport slave  (input req, mask, clr, output gnt, ack, rdata, bank_q, busy);
endinterface

// File: rtl/tff_bank_arbiter.sv
// Round-robin arbiter that serialises toggle masks from NREQ clients onto one bank
// of WIDTH T flip-flops (IDLE -> APPLY -> ACK per transaction).
module tff_bank_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    tff_bank_arbiter_if.slave bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, APPLY, ACK} state_t;

    state_t           state;
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    win_q;
    logic [NREQ-1:0]  gnt;
    logic             ack;
    logic             busy;
    logic [WIDTH-1:0] rdata;
    logic [WIDTH-1:0] mask_l;
    logic [WIDTH-1:0] bank_q;
    logic [WIDTH-1:0] t_in;

    // Rotating priority scan starting at ptr
    logic             found;
    logic [PW-1:0]    win;
    logic [WIDTH-1:0] mask_sel;
    always_comb begin
        int idx;
        found    = 1'b0;
        win      = '0;
        idx      = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(ptr) + i) % NREQ;
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                win   = PW'(idx);
            end
        end
        mask_sel = bus.mask[int'(win)*WIDTH +: WIDTH];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            ptr    <= '0;
            win_q  <= '0;
            gnt    <= '0;
            ack    <= 1'b0;
            busy   <= 1'b0;
            rdata  <= '0;
            mask_l <= '0;
        end else begin
            case (state)
                IDLE: if (found) begin
                    mask_l <= mask_sel;
                    win_q  <= win;
                    gnt    <= {{(NREQ-1){1'b0}}, 1'b1} << win;
                    busy   <= 1'b1;
                    state  <= APPLY;
                end
                APPLY: begin
                    // clr wins over the toggle, so the readback reflects the cleared bank
                    rdata <= bus.clr ? '0 : (bank_q ^ mask_l);
                    ack   <= 1'b1;
                    state <= ACK;
                end
                ACK: begin
                    gnt   <= '0;
                    ack   <= 1'b0;
                    busy  <= 1'b0;
                    ptr   <= (win_q == PW'(NREQ-1)) ? '0 : win_q + PW'(1);
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // T inputs are only ever driven by the latched mask during APPLY
    assign t_in = (state == APPLY) ? mask_l : '0;

    for (genvar b = 0; b < WIDTH; b++) begin : g_tff
        always_ff @(posedge clk or negedge rst) begin
            if (!rst)         bank_q[b] <= 1'b0;
            else if (bus.clr) bank_q[b] <= 1'b0;
            else              bank_q[b] <= t_in[b] ^ bank_q[b];
        end
    end

    assign bus.gnt    = gnt;
    assign bus.ack    = ack;
    assign bus.busy   = busy;
    assign bus.rdata  = rdata;
    assign bus.bank_q = bank_q;
endmodule

// File: tb/tb_tff_bank_arbiter.sv
// Directed bench for tff_bank_arbiter: a transaction table plus hand-written
// sequences for mask hold, async reset mid-transaction and idle clear.
module tb_tff_bank_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    tff_bank_arbiter_if #(.NREQ(4), .WIDTH(8)) bus ();
    tff_bank_arbiter #(.NREQ(4), .WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req;
        logic [31:0] mask;
        logic        clr;
        logic [3:0]  gnt;
        logic [7:0]  bank;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.req  = '0;
        bus.mask = '0;
        bus.clr  = 1'b0;

        // masks {m3,m2,m1,m0}; bank/rdata after E1 computed by hand from the running bank
        vecs[0]  = '{4'b0001, 32'h000000A5, 1'b0, 4'b0001, 8'hA5};
        vecs[1]  = '{4'b0001, 32'h000000A5, 1'b0, 4'b0001, 8'h00};
        vecs[2]  = '{4'b1000, 32'h00000000, 1'b0, 4'b1000, 8'h00}; // zero mask, ptr -> 0
        vecs[3]  = '{4'b1111, 32'h08040201, 1'b0, 4'b0001, 8'h01};
        vecs[4]  = '{4'b1111, 32'h08040201, 1'b0, 4'b0010, 8'h03};
        vecs[5]  = '{4'b1111, 32'h08040201, 1'b0, 4'b0100, 8'h07};
        vecs[6]  = '{4'b1111, 32'h08040201, 1'b0, 4'b1000, 8'h0F};
        vecs[7]  = '{4'b1111, 32'h08040201, 1'b0, 4'b0001, 8'h0E};
        vecs[8]  = '{4'b1000, 32'h00000000, 1'b0, 4'b1000, 8'h0E}; // wrap ptr -> 0
        vecs[9]  = '{4'b1010, 32'h08040201, 1'b0, 4'b0010, 8'h0C}; // skips 3
        vecs[10] = '{4'b0011, 32'h08040201, 1'b0, 4'b0001, 8'h0D}; // ptr=2, wraps to 0
        vecs[11] = '{4'b0100, 32'h00F20000, 1'b0, 4'b0100, 8'hFF};
        vecs[12] = '{4'b0100, 32'h000F0000, 1'b1, 4'b0100, 8'h00}; // clr on APPLY

        // reset then idle
        #12;
        chk("rst_bank", {24'd0, bus.bank_q}, 32'h0);
        chk("rst_gnt",  {28'd0, bus.gnt}, 32'h0);
        rst = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("idle_state", {bus.gnt, bus.ack, bus.busy, bus.bank_q}, 32'h0);
        end

        foreach (vecs[i]) begin
            bus.req  = vecs[i].req;
            bus.mask = vecs[i].mask;
            tick(); // E0: grant
            chk($sformatf("v%0d_gnt", i), {28'd0, bus.gnt}, {28'd0, vecs[i].gnt});
            chk($sformatf("v%0d_busy_ack", i), {30'd0, bus.busy, bus.ack}, 32'h2);
            bus.clr = vecs[i].clr;
            tick(); // E1: toggle + ack
            bus.clr = 1'b0;
            chk($sformatf("v%0d_ack", i), {31'd0, bus.ack}, 32'h1);
            chk($sformatf("v%0d_bank", i), {24'd0, bus.bank_q}, {24'd0, vecs[i].bank});
            chk($sformatf("v%0d_rdata", i), {24'd0, bus.rdata}, {24'd0, vecs[i].bank});
            chk($sformatf("v%0d_gnt_hold", i), {28'd0, bus.gnt}, {28'd0, vecs[i].gnt});
            tick(); // E2: release
            chk($sformatf("v%0d_release", i), {26'd0, bus.gnt, bus.ack, bus.busy}, 32'h0);
        end

        // mask/req changes after the grant edge must not affect the transaction (ptr=3 -> 0 wins)
        bus.req  = 4'b0001;
        bus.mask = 32'h0000003C;
        tick();
        chk("hold_gnt", {28'd0, bus.gnt}, 32'h1);
        bus.req  = 4'b0000;
        bus.mask = 32'hFFFFFFFF;
        tick();
        chk("hold_bank", {24'd0, bus.bank_q}, 32'h3C);
        chk("hold_ack",  {31'd0, bus.ack}, 32'h1);
        tick();
        chk("hold_release", {26'd0, bus.gnt, bus.ack, bus.busy}, 32'h0);

        // async reset during APPLY: everything clears without a clock edge, no ack
        bus.req  = 4'b0010;
        bus.mask = 32'h00005500;
        tick();
        chk("ar_gnt", {28'd0, bus.gnt}, 32'h2);
        #3 rst = 1'b0;
        #1;
        chk("ar_cleared", {bus.gnt, bus.ack, bus.busy, bus.bank_q}, 32'h0);
        bus.req = 4'b0000;
        #1 rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("ar_no_ack", {bus.gnt, bus.ack, bus.busy, bus.bank_q}, 32'h0);
        end
        // ptr back to 0, so requester 0 beats 1 (ptr was 1 before reset)
        bus.req  = 4'b0011;
        bus.mask = 32'h00000081;
        tick();
        chk("ar_ptr0_gnt", {28'd0, bus.gnt}, 32'h1);
        tick();
        chk("ar_bank", {24'd0, bus.bank_q}, 32'h81);
        bus.req = 4'b0000;
        tick();

        // clr in IDLE clears the bank and starts nothing
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
        chk("idle_clr", {bus.gnt, bus.ack, bus.busy, bus.bank_q}, 32'h0);
        tick();
        chk("idle_clr_stay", {bus.gnt, bus.ack, bus.busy, bus.bank_q}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // grant must always be one-hot or zero, and ack only with a grant held
    always @(negedge clk) if (rst) begin
        chk("gnt_onehot0", {31'd0, $onehot0(bus.gnt)}, 32'h1);
        if (bus.ack) chk("ack_with_gnt", {31'd0, |bus.gnt}, 32'h1);
    end
endmodule
